mc_control_unit: RTL

- Multicycle RV32I control FSM; the initiator side of the ALU interface.
- Decodes the latched instruction fields, then sequences fetch/decode/execute/memory/writeback.
- Drives ALUControl (funct3 encoding), operand selects and datapath write strobes; consumes Zero.
- Sits between the instruction register fields and the shared-memory multicycle datapath.

---
 rtl/mc_control_unit.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
//
// Control FSM for a multicycle RV32I core that shares one memory for
// instructions and data. It sequences each instruction through
// fetch / decode / execute / memory / writeback, drives the ALU operation
// and operand selects (it is the initiator side of the ALU interface), and
// raises the datapath write strobes at the right moments.
//
// Optional feature (macro CTRL_ILLEGAL_TRAP_EN):
//   defined   - unknown opcodes and reserved branch funct3 values park the
//               FSM in TRAP and raise the sticky Illegal flag until rst.
//   undefined - such instructions fall back to FETCH with no strobes (NOP),
//               the Illegal port does not exist and TRAP is unreachable.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   Op              instruction opcode [6:0]
//   Funct3          instruction [14:12]
//   Funct7b5        instruction bit 30 (sub / sra qualifier)
//   Zero            ALU result == 0
//   MemReady        memory finishes the current access this cycle
//   PCWrite         load PC from the result bus
//   AdrSrc          memory address select: 0 = PC, 1 = ALUOut register
//   MemRead         memory read request
//   MemWrite        memory write request
//   IRWrite         latch instruction register and OldPC
//   RegWrite        register file write
//   ResultSrc       00 = ALUOut reg, 01 = read data, 10 = ALUResult
//   ALUSrcA         00 = PC, 01 = OldPC, 10 = RD1, 11 = zero
//   ALUSrcB         00 = RD2, 01 = ImmExt, 10 = constant 4
//   ALUControl      funct3-coded ALU operation
//   ALUAlt          sub / sra qualifier
//   State           current FSM state (debug)
//   Illegal         sticky trap flag (only with CTRL_ILLEGAL_TRAP_EN)
// ---------------------------------------------------------------------------
module mc_control_unit #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         Op,
   input  logic [2:0]         Funct3,
   input  logic               Funct7b5,
   input  logic               Zero,
   input  logic               MemReady,
   output logic               PCWrite,
   output logic               AdrSrc,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [2:0]         ALUControl,
   output logic               ALUAlt,
   output logic [STATE_W-1:0] State
`ifdef CTRL_ILLEGAL_TRAP_EN
   ,
   output logic               Illegal
`endif
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_JALR2    = 4'd12,
      S_LUI      = 4'd13,
      S_TRAP     = 4'd14
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT  = 2'b00;
   localparam logic [1:0] RES_RDATA   = 2'b01;
   localparam logic [1:0] RES_ALURSLT = 2'b10;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SLT  = 3'b010;
   localparam logic [2:0] ALU_SLTU = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;

   // Where an unrecognised instruction goes: the trap state when trapping
   // is built in, otherwise straight back to fetch so it behaves as a NOP.
`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam state_t ILLEGAL_NEXT = S_TRAP;
`else
   localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

   state_t state_q;
   state_t state_d;

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal_q;
   logic illegal_d;
`endif

   // Funct3 values 010 and 011 are reserved in the branch opcode space.
   logic branch_f3_bad;
   assign branch_f3_bad = (Funct3 == 3'b010) || (Funct3 == 3'b011);

   // Next-state logic. Memory states only advance on MemReady; every other
   // state moves on unconditionally, so MemReady is don't-care there.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (Op)
               OP_LOAD,
               OP_STORE:  state_d = S_MEMADR;
               OP_RTYPE:  state_d = S_EXECR;
               OP_ITYPE:  state_d = S_EXECI;
               OP_BRANCH: state_d = S_BRANCH;
               OP_JAL:    state_d = S_JAL;
               OP_JALR:   state_d = S_JALR;
               OP_LUI:    state_d = S_LUI;
               default:   state_d = ILLEGAL_NEXT;
            endcase
         end
         S_MEMADR:   state_d = (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH:   state_d = branch_f3_bad ? ILLEGAL_NEXT : S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_JALR:     state_d = S_JALR2;
         S_JALR2:    state_d = S_ALUWB;
         S_LUI:      state_d = S_ALUWB;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;
      endcase
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   // The trap flag rises on the same edge that enters TRAP and then holds.
   always_comb begin
      illegal_d = illegal_q | (state_d == S_TRAP);
   end
`endif

   // State register (and sticky trap flag), synchronously reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   // Output decode. Mostly Moore on the current state; the exceptions are
   // the FETCH strobes (gated by MemReady so PC and IR update only when the
   // instruction word is actually present), the funct3-driven ALU op in the
   // execute and branch states, and the branch-taken PCWrite. Reset
   // overrides everything so an abandoned instruction never fires a strobe.
   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RD2;
      ALUControl = ALU_ADD;
      ALUAlt     = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemRead   = 1'b1;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURSLT;
            IRWrite   = MemReady;
            PCWrite   = MemReady;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: begin
            AdrSrc  = 1'b1;
            MemRead = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = RES_RDATA;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA    = SRCA_RD1;
            ALUSrcB    = SRCB_RD2;
            ALUControl = Funct3;
            ALUAlt     = ((Funct3 == 3'b000) || (Funct3 == 3'b101)) ? Funct7b5 : 1'b0;
         end
         S_EXECI: begin
            ALUSrcA    = SRCA_RD1;
            ALUSrcB    = SRCB_IMM;
            ALUControl = Funct3;
            // addi has no subtract form, so only srai/srli use bit 30.
            ALUAlt     = (Funct3 == 3'b101) ? Funct7b5 : 1'b0;
         end
         S_ALUWB: begin
            ResultSrc = RES_ALUOUT;
            RegWrite  = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA   = SRCA_RD1;
            ALUSrcB   = SRCB_RD2;
            ResultSrc = RES_ALUOUT;
            // eq/ne compare via XOR; lt/ge via set-less-than, whose result
            // is nonzero exactly when the "less than" relation holds.
            case (Funct3)
               3'b000: begin ALUControl = ALU_XOR;  PCWrite = Zero;  end
               3'b001: begin ALUControl = ALU_XOR;  PCWrite = ~Zero; end
               3'b100: begin ALUControl = ALU_SLT;  PCWrite = ~Zero; end
               3'b101: begin ALUControl = ALU_SLT;  PCWrite = Zero;  end
               3'b110: begin ALUControl = ALU_SLTU; PCWrite = ~Zero; end
               3'b111: begin ALUControl = ALU_SLTU; PCWrite = Zero;  end
               default: begin ALUControl = ALU_ADD; PCWrite = 1'b0;  end
            endcase
         end
         S_JAL: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALUOUT;
            PCWrite   = 1'b1;
         end
         S_JALR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
         end
         S_JALR2: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALUOUT;
            PCWrite   = 1'b1;
         end
         S_LUI: begin
            ALUSrcA = SRCA_ZERO;
            ALUSrcB = SRCB_IMM;
         end
         default: begin
         end
      endcase

      if (rst) begin
         PCWrite    = 1'b0;
         AdrSrc     = 1'b0;
         MemRead    = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         RegWrite   = 1'b0;
         ResultSrc  = 2'b00;
         ALUSrcA    = 2'b00;
         ALUSrcB    = 2'b00;
         ALUControl = 3'b000;
         ALUAlt     = 1'b0;
      end
   end

   assign State = state_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
   assign Illegal = illegal_q;
`endif

endmodule
